// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package alu_muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // MULT and DIV are the signed variants (even encodings).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/alu_muldiv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem, dbit};
    assign diff    = shifted - {1'b0, divisor};

    // With rem < divisor the borrow bit alone decides; a zero divisor is overridden upstream.
    assign qbit     = ~diff[WIDTH];
    assign rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle, fixed latency WIDTH+1.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic [CNT_W-1:0]   cnt;
    logic               is_div_r;
    logic               neg_q;
    logic               neg_r;
    logic               dbz_r;

    // Launch-time magnitudes and signs
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign sgn   = op_is_signed(op);
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each cycle
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_mul;

    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    assign acc_mul = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left each cycle
    logic [WIDTH-1:0]   rem_nx;
    logic               qbit;
    logic [2*WIDTH-1:0] acc_div;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem      (acc[2*WIDTH-1:WIDTH]),
        .dbit     (acc[WIDTH-1]),
        .divisor  (opnd),
        .rem_next (rem_nx),
        .qbit     (qbit)
    );

    assign acc_div = {rem_nx, acc[WIDTH-2:0], qbit};

    // Sign correction applied at FIX
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            acc         <= '0;
            opnd        <= '0;
            a_raw       <= '0;
            cnt         <= '0;
            is_div_r    <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // An MTHI/MTLO coinciding with start lands now; the result overwrites it later.
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div_r <= op_is_div(op);
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        dbz_r    <= op_is_div(op) && (b == '0);
                        a_raw    <= a;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_CALC;
                        if (op_is_div(op)) begin
                            opnd <= b_mag;
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                ST_CALC: begin
                    acc <= is_div_r ? acc_div : acc_mul;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (!is_div_r) begin
                        {hi, lo} <= prod_fix;
                    end else if (dbz_r) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    div_by_zero <= dbz_r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv at WIDTH=32 and WIDTH=8 with directed vectors.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          sc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        hi_we8, lo_we8;
    logic [7:0]  wdata8;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    alu_muldiv #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
    );

    alu_muldiv #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q32[$];
    exp_t q8[$];
    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon32
        exp_t e;
        if (done === 1'b1) begin
            if (q32.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL done32: unexpected done pulse at cycle %0d", cyc);
            end else begin
                e = q32.pop_front();
                chk("hi32", hi, e.hi);
                chk("lo32", lo, e.lo);
                chk("dbz32", 32'(dbz), 32'(e.dbz));
                chk("latency32", 32'(cyc - e.sc), 32'd33);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL done8: unexpected done pulse at cycle %0d", cyc);
            end else begin
                e = q8.pop_front();
                chk("hi8", 32'(hi8), e.hi);
                chk("lo8", 32'(lo8), e.lo);
                chk("dbz8", 32'(dbz8), 32'(e.dbz));
                chk("latency8", 32'(cyc - e.sc), 32'd9);
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                         input bit push);
        op = o; a = x; b = y; start = 1'b1;
        if (push) q32.push_back('{hi: ehi, lo: elo, dbz: edbz, sc: cyc + 1});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] ehi, input logic [7:0] elo, input logic edbz);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        q8.push_back('{hi: 32'(ehi), lo: 32'(elo), dbz: edbz, sc: cyc + 1});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            nvec++;
            nerr++;
            $display("FAIL %s: done not seen within 100 cycles", name);
        end
    endtask

    task automatic wait_done8(input string name);
        int n = 0;
        while (done8 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done8 !== 1'b1) begin
            nvec++;
            nerr++;
            $display("FAIL %s: done not seen within 100 cycles", name);
        end
    endtask

    initial begin
        logic [31:0] prev_lo;
        int          n;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        hi_we8 = 1'b0; lo_we8 = 1'b0; wdata8 = '0;

        tbl.push_back('{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0});
        tbl.push_back('{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 1'b0});
        tbl.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        tbl.push_back('{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0});
        tbl.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0});
        tbl.push_back('{OP_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1});
        tbl.push_back('{OP_MULTU, 32'd2,        32'd2,        32'd0,        32'd4,        1'b0});
        tbl.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0});
        tbl.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0});
        tbl.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1});
        tbl.push_back('{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0});
        prev_lo = tbl[tbl.size()-1].lo;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(dbz), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: each start lands in the cycle done is high
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dbz, 1'b1);
            if (i == 0) chk("busy_running", 32'(busy), 32'd1);
            wait_done("vec");
        end

        // MTHI coinciding with start, then a start and MTLO while busy (both ignored)
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
        issue(OP_MULT, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 1'b0, 1'b1);
        hi_we = 1'b0;
        chk("mthi_with_start", hi, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        lo_we = 1'b1; wdata = 32'h000000A5;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        chk("mtlo_while_busy", lo, prev_lo);
        wait_done("interfere");
        lo_we = 1'b1; wdata = 32'h000000A5;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_idle_lo", lo, 32'h000000A5);
        chk("mtlo_idle_hi", hi, 32'h00000012);

        // Reset mid-divide discards the operation
        repeat (2) @(negedge clk);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
        wait_done("divu_after_rst");
        @(negedge clk);

        // Narrow instance
        issue8(OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0);
        wait_done8("mult8");
        issue8(OP_DIV, 8'h81, 8'h03, 8'hFF, 8'hD6, 1'b0);
        wait_done8("div8");
        issue8(OP_DIVU, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1);
        wait_done8("divu8_zero");
        issue8(OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
        wait_done8("multu8");

        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q32.size() != 0 || q8.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain: %0d/%0d results never arrived", q32.size(), q8.size());
        end
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, multi-cycle multiply/divide unit extending the combinational ALU to the MIPS MULT/MULTU/DIV/DIVU instructions.
- Owns the HI/LO register pair, including MTHI/MTLO writes.
- Sits beside the single-cycle ALU in the execute stage; the control unit stalls the pipeline while busy=1.
- Iterative, one bit per cycle, constant latency for every operation.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; any value ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  launch an operation; sampled only while busy=0.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  sticky flag for the last completed operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0: latch a, b, op; take the magnitudes of a and b for signed ops and record the result signs.
  - Go to CALC; busy=1 from E0.
- CALC: exactly WIDTH cycles (edges E1..E_WIDTH), then go to FIX.
  - Multiply: shift-add on unsigned magnitudes into a 2·WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
- FIX: at edge E(WIDTH+1):
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo; pulse done=1 for one cycle; busy=0; return to IDLE.
- Latency: done rises WIDTH+1 edges after the start edge (33 at WIDTH=32). A new start is accepted in the same cycle done=1.
- Result mapping:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Arithmetic: all intermediate values are unsigned magnitudes; no truncation before FIX.
- Divide by zero (b=0, DIV or DIVU):
  - Same latency; lo = all ones, hi = a unchanged; div_by_zero=1.
  - Any other completed op clears div_by_zero.
- Signed overflow (DIV of most-negative by −1): lo = most-negative value, hi = 0. No trap, no flag.
- start while busy=1: ignored; latched operands are unaffected.
- hi_we/lo_we:
  - Honoured only while busy=0; write at the edge, visible next cycle.
  - Ignored while busy=1.
  - If hi_we/lo_we and start coincide, the write takes effect and the operation starts; the operation's result later overwrites the write.
- hi/lo hold their value at all times except the FIX edge, MTHI/MTLO writes, and reset.

Decomposition:
- Shared package holds:
  - Op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - FSM state encoding.
- One combinational sub-module, div_restore_step: (partial remainder, dividend bit, divisor) → (next remainder, quotient bit). Instantiated once in alu_muldiv.
- The multiply step stays inline.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 → done at edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1. A following MULTU 2×2 → lo=4, hi=0, div_by_zero=0.
- Pulse start at edge 5 of a running MULT with different operands → result unchanged, done pulses once. lo_we=1 with wdata=0xA5 during busy → ignored. lo_we after done → lo=0xA5 next cycle.
- Assert rst at edge 10 of a DIV → busy, done, hi, lo all 0 immediately. After release, a fresh DIVU 100/7 → lo=14, hi=2.
- WIDTH=8: MULT 0x80×0x80 → {hi,lo}=0x4000; DIV 0x81/0x03 → lo=0xD6, hi=0xFF; done 9 edges after start.
